// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: default widths, response flag bit positions,
// request field layout and FSM state encodings.
package alu_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CMD_WIDTH  = 4;
   localparam int ID_WIDTH       = 8;
   localparam int FLG_WIDTH      = 6;

   // Bit positions inside rsp_flags = {cout,oflow,g,l,e,err}
   localparam int FLG_COUT  = 5;
   localparam int FLG_OFLOW = 4;
   localparam int FLG_G     = 3;
   localparam int FLG_L     = 2;
   localparam int FLG_E     = 1;
   localparam int FLG_ERR   = 0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef struct packed {
      logic [ID_WIDTH-1:0]       id;
      logic                      mode;
      logic [DEF_CMD_WIDTH-1:0]  cmd;
      logic [1:0]                inp_valid;
      logic                      cin;
      logic [DEF_DATA_WIDTH-1:0] opa;
      logic [DEF_DATA_WIDTH-1:0] opb;
   } alu_req_t;

   function automatic int req_width(input int dw, input int cw);
      return ID_WIDTH + 1 + cw + 2 + 1 + 2 * dw;
   endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO with registered occupancy count; read data is the current head.
module alu_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_s;
   logic             pop_s;

   assign push_s  = push && (count_r != FULL_CNT);
   assign pop_s   = pop && (count_r != '0);
   assign rd_data = mem_r[rd_ptr_r];
   assign full    = (count_r == FULL_CNT);
   assign empty   = (count_r == '0);
   assign count   = count_r;

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (AW + 1)'(1);
            2'b01:   count_r <= count_r - (AW + 1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: request FIFO, registered ALU pin drive, ID tag pipe and tagged response capture.
// Optional counters stat_issued/stat_errs are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int ALU_LAT    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ID_WIDTH-1:0]     req_id,
   input  logic                    req_mode,
   input  logic [CMD_WIDTH-1:0]    req_cmd,
   input  logic [1:0]              req_inp_valid,
   input  logic                    req_cin,
   input  logic [DATA_WIDTH-1:0]   req_opa,
   input  logic [DATA_WIDTH-1:0]   req_opb,
   input  logic                    flush,
   output logic                    flush_done,
   output logic                    alu_ce,
   output logic                    alu_mode,
   output logic                    alu_cin,
   output logic [1:0]              alu_inp_valid,
   output logic [CMD_WIDTH-1:0]    alu_cmd,
   output logic [DATA_WIDTH-1:0]   alu_opa,
   output logic [DATA_WIDTH-1:0]   alu_opb,
   input  logic [2*DATA_WIDTH:0]   alu_res,
   input  logic                    alu_cout,
   input  logic                    alu_oflow,
   input  logic                    alu_g,
   input  logic                    alu_l,
   input  logic                    alu_e,
   input  logic                    alu_err,
   output logic                    rsp_valid,
   output logic [ID_WIDTH-1:0]     rsp_id,
   output logic [2*DATA_WIDTH:0]   rsp_res,
   output logic [FLG_WIDTH-1:0]    rsp_flags
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [15:0]             stat_issued,
   output logic [15:0]             stat_errs
`endif
);
   localparam int REQ_W = req_width(DATA_WIDTH, CMD_WIDTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [REQ_W-1:0]      wr_data_s;
   logic [REQ_W-1:0]      rd_data_s;
   logic                  push_s, pop_s, full_s, empty_s;
   logic [CNT_W-1:0]      count_s, count_next_s;
   logic [ID_WIDTH-1:0]   hd_id_s;
   logic                  hd_mode_s, hd_cin_s;
   logic [CMD_WIDTH-1:0]  hd_cmd_s;
   logic [1:0]            hd_inp_valid_s;
   logic [DATA_WIDTH-1:0] hd_opa_s, hd_opb_s;
   logic [1:0]            state_r, state_next_s;
   logic                  pipe_empty_s, drain_done_s, done_next_s;
   logic [ID_WIDTH-1:0]   alu_id_r;
   logic [ALU_LAT-1:0]    pipe_vld_r;
   logic [ID_WIDTH-1:0]   pipe_id_r [ALU_LAT];

   assign push_s    = req_valid && req_ready && !full_s;
   assign pop_s     = !empty_s;
   assign wr_data_s = {req_id, req_mode, req_cmd, req_inp_valid, req_cin, req_opa, req_opb};
   assign {hd_id_s, hd_mode_s, hd_cmd_s, hd_inp_valid_s, hd_cin_s, hd_opa_s, hd_opb_s} = rd_data_s;

   alu_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_s),
      .pop     (pop_s),
      .wr_data (wr_data_s),
      .rd_data (rd_data_s),
      .full    (full_s),
      .empty   (empty_s),
      .count   (count_s)
   );

   // An op stays in flight from the issue register until it leaves the tag pipe
   assign pipe_empty_s = !alu_ce && (pipe_vld_r == '0);
   assign drain_done_s = empty_s && pipe_empty_s;
   assign done_next_s  = (state_r == ST_DRAIN) && drain_done_s && !flush;

   // Occupancy after this edge, used to register req_ready
   always_comb begin
      count_next_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
   end

   // Next-state logic; flush overrides every state
   always_comb begin
      state_next_s = state_r;
      if (flush) begin
         state_next_s = ST_DRAIN;
      end else begin
         case (state_r)
            ST_IDLE:  if (!empty_s)     state_next_s = ST_ISSUE; else state_next_s = ST_IDLE;
            ST_ISSUE: if (drain_done_s) state_next_s = ST_IDLE;  else state_next_s = ST_ISSUE;
            ST_DRAIN: if (drain_done_s) state_next_s = ST_IDLE;  else state_next_s = ST_DRAIN;
            default:  state_next_s = ST_IDLE;
         endcase
      end
   end

   // State, registered ready and flush completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         req_ready  <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         req_ready  <= (state_next_s != ST_DRAIN) && (count_next_s != FULL_CNT);
         flush_done <= done_next_s;
      end
   end

   // ALU pin registers: idle cycles drop ce and inp_valid but hold the operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_ce        <= 1'b0;
         alu_mode      <= 1'b0;
         alu_cin       <= 1'b0;
         alu_inp_valid <= 2'b00;
         alu_cmd       <= '0;
         alu_opa       <= '0;
         alu_opb       <= '0;
         alu_id_r      <= '0;
      end else if (pop_s) begin
         alu_ce        <= 1'b1;
         alu_mode      <= hd_mode_s;
         alu_cin       <= hd_cin_s;
         alu_inp_valid <= hd_inp_valid_s;
         alu_cmd       <= hd_cmd_s;
         alu_opa       <= hd_opa_s;
         alu_opb       <= hd_opb_s;
         alu_id_r      <= hd_id_s;
      end else begin
         alu_ce        <= 1'b0;
         alu_inp_valid <= 2'b00;
      end
   end

   // Tag pipe starts on the edge the ALU samples alu_ce, so its exit lines up with valid ALU outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld_r <= '0;
         for (int i = 0; i < ALU_LAT; i++) pipe_id_r[i] <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_res    <= '0;
         rsp_flags  <= '0;
      end else begin
         pipe_vld_r[0] <= alu_ce;
         pipe_id_r[0]  <= alu_id_r;
         for (int i = 1; i < ALU_LAT; i++) begin
            pipe_vld_r[i] <= pipe_vld_r[i-1];
            pipe_id_r[i]  <= pipe_id_r[i-1];
         end
         rsp_valid <= pipe_vld_r[ALU_LAT-1];
         if (pipe_vld_r[ALU_LAT-1]) begin
            rsp_id               <= pipe_id_r[ALU_LAT-1];
            rsp_res              <= alu_res;
            rsp_flags[FLG_COUT]  <= alu_cout;
            rsp_flags[FLG_OFLOW] <= alu_oflow;
            rsp_flags[FLG_G]     <= alu_g;
            rsp_flags[FLG_L]     <= alu_l;
            rsp_flags[FLG_E]     <= alu_e;
            rsp_flags[FLG_ERR]   <= alu_err;
         end else begin
            rsp_id    <= rsp_id;
            rsp_res   <= rsp_res;
            rsp_flags <= rsp_flags;
         end
      end
   end

`ifdef ALU_ISSUE_STATS_EN
   // Saturating issue/error counters, cleared together with the flush_done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued <= 16'h0000;
         stat_errs   <= 16'h0000;
      end else if (done_next_s) begin
         stat_issued <= 16'h0000;
         stat_errs   <= 16'h0000;
      end else begin
         if (pop_s && (stat_issued != 16'hFFFF)) stat_issued <= stat_issued + 16'h0001;
         if (pipe_vld_r[ALU_LAT-1] && alu_err && (stat_errs != 16'hFFFF)) stat_errs <= stat_errs + 16'h0001;
      end
   end
`endif

endmodule
